proc_cmd_receiver: RTL and testbench

Per-processor front end that sits directly downstream of the command issuer, one instance per SIMD processor. It claims the processor on the issuer's enable strobe and captures the three-instruction sequence LD, LD, INFO, acknowledging each instruction. It then streams `count` element operations into the SIMD datapath with a valid/ready handshake, waits for write-back drain, and raises `finish` until the issuer acknowledges it. Its `o_busy` and `o_finish` feed the issuer's per-processor busy and finish vectors.

---
 rtl/proc_cmd_receiver.sv | 199 +++++++++++++++++++
 tb/tb_proc_cmd_receiver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_cmd_receiver.sv
// ----------------------------------------------------------------------------
// proc_cmd_receiver
//
// Per-processor front end downstream of the command issuer. Claims the
// processor on i_en, captures LD / LD / INFO (acking each instruction),
// streams `count` element operations into the SIMD datapath with a
// valid/ready handshake, waits for write-back drain, then holds o_finish
// until the issuer acknowledges it on i_vld.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_en              issuer enable strobe (claims this processor)
//   i_vld             qualifies i_instr; also the finish acknowledge
//   i_instr           instruction {opcode[1:0], payload}
//   o_ack             one-cycle accept pulse per instruction
//   o_busy            processor claimed or working
//   o_finish          command complete, held until acknowledged
//   o_err             one-cycle pulse on a protocol violation
//   o_dp_vld/i_dp_rdy element handshake to the SIMD datapath
//   o_dp_addr0/1      element operand addresses
//   o_dp_wr_addr      element result address
//   o_dp_op           SIMD opcode, constant through EXEC
//   i_dp_done         all accepted elements written back
// ----------------------------------------------------------------------------
module proc_cmd_receiver #(
   parameter int ADDR_W  = 16,
   parameter int CNT_W   = 8,
   parameter int OP_W    = 4,
   parameter int INSTR_W = 2 + ADDR_W + OP_W + CNT_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic               i_vld,
   input  logic [INSTR_W-1:0] i_instr,
   output logic               o_ack,
   output logic               o_busy,
   output logic               o_finish,
   output logic               o_err,
   output logic               o_dp_vld,
   input  logic               i_dp_rdy,
   output logic [ADDR_W-1:0]  o_dp_addr0,
   output logic [ADDR_W-1:0]  o_dp_addr1,
   output logic [ADDR_W-1:0]  o_dp_wr_addr,
   output logic [OP_W-1:0]    o_dp_op,
   input  logic               i_dp_done
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_LD1  = 3'd1;
   localparam logic [2:0] S_WAIT_LD2  = 3'd2;
   localparam logic [2:0] S_WAIT_INFO = 3'd3;
   localparam logic [2:0] S_EXEC      = 3'd4;
   localparam logic [2:0] S_DRAIN     = 3'd5;
   localparam logic [2:0] S_FINISH    = 3'd6;

   localparam logic [1:0] INSTR_LD   = 2'b01;
   localparam logic [1:0] INSTR_INFO = 2'b10;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr0_q, addr0_d;
   logic [ADDR_W-1:0] addr1_q, addr1_d;
   logic [ADDR_W-1:0] wr_q, wr_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              fin_q, fin_d;
   logic              dpv_q, dpv_d;

   logic [1:0]        opc;
   logic [ADDR_W-1:0] pl_addr;
   logic [CNT_W-1:0]  pl_cnt;
   logic [OP_W-1:0]   pl_op;

   assign opc     = i_instr[INSTR_W-1 -: 2];
   assign pl_addr = i_instr[ADDR_W-1:0];
   assign pl_cnt  = i_instr[CNT_W+OP_W+ADDR_W-1 -: CNT_W];
   assign pl_op   = i_instr[OP_W+ADDR_W-1 -: OP_W];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr0_d = addr0_q;
      addr1_d = addr1_q;
      wr_d    = wr_q;
      op_d    = op_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // i_vld without i_en (or together with it) is dropped here
            if (i_en) state_d = S_WAIT_LD1;
         end
         S_WAIT_LD1: begin
            if (i_vld) begin
               ack_d = 1'b1;
               if (opc == INSTR_LD) begin
                  addr0_d = pl_addr;
                  state_d = S_WAIT_LD2;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT_LD2: begin
            if (i_vld) begin
               ack_d = 1'b1;
               if (opc == INSTR_LD) begin
                  addr1_d = pl_addr;
                  state_d = S_WAIT_INFO;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT_INFO: begin
            if (i_vld) begin
               ack_d = 1'b1;
               if (opc == INSTR_INFO) begin
                  cnt_d   = pl_cnt;
                  op_d    = pl_op;
                  wr_d    = pl_addr;
                  state_d = (pl_cnt == '0) ? S_FINISH : S_EXEC;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_EXEC: begin
            // the working address registers drive o_dp_* directly, so the
            // first element presents exactly the captured values
            if (i_dp_rdy) begin
               addr0_d = addr0_q + ADDR_W'(1);
               addr1_d = addr1_q + ADDR_W'(1);
               wr_d    = wr_q + ADDR_W'(1);
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (i_dp_done) state_d = S_FINISH;
         end
         S_FINISH: begin
            if (i_vld) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // status outputs are registered views of the next state
      busy_d = (state_d != S_IDLE);
      fin_d  = (state_d == S_FINISH);
      dpv_d  = (state_d == S_EXEC);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr0_q <= '0;
         addr1_q <= '0;
         wr_q    <= '0;
         op_q    <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
         dpv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr0_q <= addr0_d;
         addr1_q <= addr1_d;
         wr_q    <= wr_d;
         op_q    <= op_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         fin_q   <= fin_d;
         dpv_q   <= dpv_d;
      end
   end

   assign o_ack        = ack_q;
   assign o_err        = err_q;
   assign o_busy       = busy_q;
   assign o_finish     = fin_q;
   assign o_dp_vld     = dpv_q;
   assign o_dp_addr0   = addr0_q;
   assign o_dp_addr1   = addr1_q;
   assign o_dp_wr_addr = wr_q;
   assign o_dp_op      = op_q;

endmodule

// File: tb/tb_proc_cmd_receiver.sv
// ----------------------------------------------------------------------------
// tb_proc_cmd_receiver
//
// Directed bench for proc_cmd_receiver. Expected datapath elements are pushed
// to a scoreboard queue when INFO is driven and popped by a monitor on every
// o_dp_vld && i_dp_rdy handshake. Inputs change 2 time units after the rising
// edge; outputs are read at that point or on the falling edge.
// ----------------------------------------------------------------------------
module tb_proc_cmd_receiver;

   localparam int AW = 16;
   localparam int CW = 8;
   localparam int OW = 4;
   localparam int IW = 2 + AW + OW + CW;

   logic          clk = 1'b0;
   logic          rst, en, vld, rdy, done;
   logic [IW-1:0] instr;
   logic          ack, busy, fin, err, dpv;
   logic [AW-1:0] a0, a1, wa;
   logic [OW-1:0] op;

   proc_cmd_receiver #(.ADDR_W(AW), .CNT_W(CW), .OP_W(OW), .INSTR_W(IW)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_vld(vld), .i_instr(instr),
      .o_ack(ack), .o_busy(busy), .o_finish(fin), .o_err(err),
      .o_dp_vld(dpv), .i_dp_rdy(rdy), .o_dp_addr0(a0), .o_dp_addr1(a1),
      .o_dp_wr_addr(wa), .o_dp_op(op), .i_dp_done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [AW-1:0] wa;
      logic [OW-1:0] op;
   } elem_t;

   elem_t sb[$];
   int    n_pass = 0;
   int    n_fail = 0;
   int    n_total = 0;
   int    hs_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // handshake monitor / scoreboard consumer
   elem_t cur, prev;
   logic  stall_q = 1'b0;
   always @(negedge clk) begin
      cur = '{a0: a0, a1: a1, wa: wa, op: op};
      if (!rst && dpv) begin
         if (stall_q) chk("stall_stable", 64'(cur), 64'(prev));
         if (rdy) begin
            hs_cnt++;
            chk("sb_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("elem", 64'(cur), 64'(sb.pop_front()));
         end
         stall_q = !rdy;
         prev    = cur;
      end else begin
         stall_q = 1'b0;
      end
   end

   // en, LD, LD, INFO; returns just after INFO has been sampled
   task automatic cmd(input logic [AW-1:0] x0, input logic [AW-1:0] x1,
                      input int cnt, input int opv, input logic [AW-1:0] xw);
      en = 1'b1;
      step();
      chk("busy_after_en", 64'(busy), 1);
      chk("no_ack_on_en", 64'(ack), 0);
      en    = 1'b0;
      vld   = 1'b1;
      instr = {2'b01, {(CW+OW){1'b0}}, x0};
      step();
      chk("ack_ld1", 64'(ack), 1);
      instr = {2'b01, {(CW+OW){1'b0}}, x1};
      step();
      chk("ack_ld2", 64'(ack), 1);
      instr = {2'b10, CW'(cnt), OW'(opv), xw};
      for (int i = 0; i < cnt; i++)
         sb.push_back('{a0: AW'(x0 + i), a1: AW'(x1 + i), wa: AW'(xw + i), op: OW'(opv)});
      step();
      chk("ack_info", 64'(ack), 1);
      chk("err_info", 64'(err), 0);
      chk("dpv_after_info", 64'(dpv), 64'(cnt != 0));
      chk("fin_after_info", 64'(fin), 64'(cnt == 0));
      vld = 1'b0;
   endtask

   // wait for the element stream to end, then drain and finish-ack
   task automatic finish_seq();
      for (int i = 0; i < 50 && dpv; i++) step();
      chk("drain_timeout", 64'(dpv), 0);
      step();
      chk("no_fin_in_drain", 64'(fin), 0);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("fin_after_done", 64'(fin), 1);
      chk("busy_in_finish", 64'(busy), 1);
      step();
      chk("fin_held", 64'(fin), 1);
      vld = 1'b1;
      step();
      vld = 1'b0;
      chk("fin_cleared", 64'(fin), 0);
      chk("busy_cleared", 64'(busy), 0);
      chk("no_ack_finack", 64'(ack), 0);
   endtask

   int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
   int h0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; en = 1'b0; vld = 1'b0; rdy = 1'b0; done = 1'b0; instr = '0;
      step();
      step();
      chk("rst_outs", 64'({ack, busy, fin, err, dpv}), 0);
      chk("rst_dp", 64'({a0, a1, wa, op}), 0);
      rst = 1'b0;
      step();

      // nominal run
      rdy = 1'b1;
      h0  = hs_cnt;
      cmd(16'h0100, 16'h0200, 3, 5, 16'h0300);
      step();
      chk("ack_single_cycle", 64'(ack), 0);
      finish_seq();
      chk("nominal_hs", 64'(hs_cnt - h0), 3);

      // backpressure
      rdy = 1'b0;
      h0  = hs_cnt;
      cmd(16'h1000, 16'h2000, 4, 3, 16'h3000);
      for (int i = 0; i < 7; i++) begin
         rdy = pat[i][0];
         step();
         chk("bp_dpv", 64'(dpv), 64'(i < 6));
      end
      chk("bp_hs", 64'(hs_cnt - h0), 4);
      rdy = 1'b1;
      finish_seq();

      // address wrap
      cmd(16'hFFFF, 16'h0010, 2, 9, 16'hFFFE);
      finish_seq();

      // zero count
      h0 = hs_cnt;
      cmd(16'h0500, 16'h0600, 0, 2, 16'h0700);
      step();
      chk("zero_dpv", 64'(dpv), 0);
      chk("zero_fin", 64'(fin), 1);
      vld = 1'b1;
      step();
      vld = 1'b0;
      chk("zero_fin_clr", 64'(fin), 0);
      chk("zero_hs", 64'(hs_cnt - h0), 0);

      // protocol error: INFO in WAIT_LD2
      en = 1'b1;
      step();
      en    = 1'b0;
      vld   = 1'b1;
      instr = {2'b01, {(CW+OW){1'b0}}, 16'h0042};
      step();
      chk("perr_ack_ld", 64'(ack), 1);
      instr = {2'b10, CW'(2), OW'(1), 16'h0050};
      step();
      vld = 1'b0;
      chk("perr_ack", 64'(ack), 1);
      chk("perr_err", 64'(err), 1);
      step();
      chk("perr_busy", 64'(busy), 0);
      chk("perr_err_pulse", 64'(err), 0);
      // back in IDLE: a lone i_vld is ignored
      vld   = 1'b1;
      instr = {2'b01, {(CW+OW){1'b0}}, 16'h0043};
      step();
      vld = 1'b0;
      chk("idle_vld_noack", 64'(ack), 0);
      chk("idle_vld_busy", 64'(busy), 0);

      // i_en and i_vld together in IDLE: enable wins, vld dropped
      en  = 1'b1;
      vld = 1'b1;
      step();
      en  = 1'b0;
      vld = 1'b0;
      chk("envld_busy", 64'(busy), 1);
      chk("envld_noack", 64'(ack), 0);
      vld   = 1'b1;
      instr = {2'b11, {(CW+OW+AW){1'b0}}};
      step();
      vld = 1'b0;
      chk("op11_err", 64'(err), 1);
      step();
      chk("op11_idle", 64'(busy), 0);

      // i_en while busy is ignored
      rdy = 1'b0;
      cmd(16'h4000, 16'h5000, 1, 2, 16'h6000);
      en = 1'b1;
      step();
      en = 1'b0;
      chk("en_busy_dpv", 64'(dpv), 1);
      chk("en_busy_addr", 64'(a0), 64'(16'h4000));
      rdy = 1'b1;
      finish_seq();

      // reset mid-EXEC
      h0 = hs_cnt;
      cmd(16'h0700, 16'h0800, 5, 1, 16'h0900);
      step();
      step();
      rst = 1'b1;
      rdy = 1'b0;
      step();
      chk("mid_rst_outs", 64'({ack, busy, fin, err, dpv}), 0);
      chk("mid_rst_dp", 64'({a0, a1, wa, op}), 0);
      chk("mid_rst_hs", 64'(hs_cnt - h0), 2);
      sb.delete();
      rst = 1'b0;
      step();
      rdy = 1'b1;
      cmd(16'h0A00, 16'h0B00, 2, 7, 16'h0C00);
      finish_seq();

      chk("sb_empty", 64'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
